exit_pay_fsm: RTL
=================

EXIT_PAY_FSM -- requirements
Module: exit_pay_fsm

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DWIDTH, 16, width of parking_time_min.
- TICKS_PER_SEC, 100_000_000, clk cycles per second.
- MAX_FEE, 20, fee cap in dollars; even, at most 98.
- PAY_TIMEOUT_SEC, 60, idle time allowed while awaiting payment.
- GATE_TIMEOUT_SEC, 5, maximum exit gate open time.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge.
- reset, in, 1, synchronous, active-high.
- exit_sensor, in, 1, car present at exit lane.
- ticket_inserted, in, 1, one-cycle pulse, ticket fed to reader.
- ticket_ok, in, 1, ticket readable; valid only with ticket_inserted.
- parking_time_min, in, DWIDTH, elapsed minutes; valid with ticket_inserted.
- bill_2, in, 1, one-cycle pulse, $2 bill accepted.
- bill_4, in, 1, one-cycle pulse, $4 bill accepted.
- attendant_clear, in, 1, attendant key, clears ERROR.
- fee_display, out, 8, remaining balance as two BCD digits, [7:4] tens.
- exit_gate, out, 1, gate open command.
- thank_you_lamp, out, 1, blinks twice after payment.
- see_attendant_lamp, out, 1, steady in ERROR.
- ticket_eject, out, 1, one-cycle pulse, returns unpaid ticket.

Function
REQ-003 The FSM SHALL have the states IDLE_X, CALC_FEE, WAIT_PAY, X_GATE_OPEN and ERROR; all outputs SHALL be registered.
REQ-004 In IDLE_X, ticket_inserted with exit_sensor=1 and ticket_ok=1 SHALL latch parking_time_min into remainder r, clear balance, and go to CALC_FEE.
REQ-005 In IDLE_X, ticket_inserted with exit_sensor=1 and ticket_ok=0 SHALL go to ERROR; ticket_inserted with exit_sensor=0 SHALL be ignored.
REQ-006 CALC_FEE SHALL run one iteration per cycle while r>0 and balance<MAX_FEE: r <= (r>60) ? r-60 : 0, and balance += 2.
REQ-007 The iteration SHALL give balance = min(2*ceil(min/60), MAX_FEE); example: 125 min takes 3 iteration cycles plus 1 exit cycle.
REQ-008 When CALC_FEE ends, balance=0 SHALL go to X_GATE_OPEN and balance>0 SHALL go to WAIT_PAY.
REQ-009 In WAIT_PAY, bill_2 SHALL subtract 2 and bill_4 SHALL subtract 4 from balance, both in the same cycle SHALL subtract 6, and the result SHALL saturate at 0 with no change given.
REQ-010 The transition to X_GATE_OPEN SHALL occur in the cycle after balance reaches 0.
REQ-011 Each accepted bill SHALL restart the payment timer.
REQ-012 If PAY_TIMEOUT_SEC*TICKS_PER_SEC cycles pass with no bill, the block SHALL pulse ticket_eject for one cycle, clear balance, and return to IDLE_X.
REQ-013 If exit_sensor falls during WAIT_PAY, the block SHALL behave as in REQ-012 on the next cycle.
REQ-014 fee_display SHALL show the BCD of balance in CALC_FEE and WAIT_PAY, and 8'h00 in all other states.
REQ-015 In X_GATE_OPEN, exit_gate SHALL be 1.
REQ-016 X_GATE_OPEN SHALL return to IDLE_X on the first exit_sensor falling edge (car passed) or after GATE_TIMEOUT_SEC, whichever comes first.
REQ-017 On entry to X_GATE_OPEN, thank_you_lamp SHALL blink on 0.5 s, off 0.5 s, on 0.5 s, then off.
REQ-018 The blink SHALL run to completion even if the state returns to IDLE_X first.
REQ-019 ERROR SHALL hold see_attendant_lamp=1 and exit_gate=0, and SHALL return to IDLE_X on attendant_clear.
REQ-020 Bill pulses outside WAIT_PAY, and ticket_inserted outside IDLE_X, SHALL be ignored.
REQ-021 A single tick counter SHALL generate timing in all states, restarting on every state entry.

Reset
REQ-022 Reset SHALL force IDLE_X, zero balance, r, timers and blink counter, and drive all outputs to 0 on the next edge, including mid-payment and with the gate open.
REQ-023 Reset SHALL take priority over every other input in the same cycle.

Verification (TICKS_PER_SEC=10)
REQ-024 Ticket ok, 125 min, then bill_4 and bill_2 -> fee_display 06, then 02, then gate opens and thank_you blinks 5 on/5 off/5 on cycles.
REQ-025 Ticket ok, 2000 min -> fee_display 20 (cap); one cycle with bill_4 and bill_2 together -> 14.
REQ-026 Ticket ok, 0 min -> no WAIT_PAY; exit_gate=1; exit_sensor falls -> gate 0 next cycle.
REQ-027 ticket_ok=0 -> see_attendant_lamp steady; bills ignored; attendant_clear -> IDLE_X, lamp 0.
REQ-028 Balance 2 with no bills for 600 cycles -> ticket_eject one pulse and IDLE_X; a separate case with no car passing -> gate closes after 50 cycles.
REQ-029 Reset asserted in WAIT_PAY and in X_GATE_OPEN -> all outputs 0 and IDLE_X one cycle later.

Source files
------------

// File: rtl/exit_pay_fsm.sv
// exit_pay_fsm: exit-lane pay station controller.
// A car presents its ticket, the fee is worked out one hour per cycle,
// bills are collected, and the gate is opened. Unreadable tickets go to
// ERROR. Unpaid tickets are ejected on a payment timeout or when the car
// backs out. Every output is a flop. Each output shows the state and
// balance that take effect on the same clock edge.
module exit_pay_fsm #(
  parameter int unsigned DWIDTH           = 16,
  parameter int unsigned TICKS_PER_SEC    = 100_000_000,
  parameter int unsigned MAX_FEE          = 20,
  parameter int unsigned PAY_TIMEOUT_SEC  = 60,
  parameter int unsigned GATE_TIMEOUT_SEC = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exit_sensor,
  input  logic              ticket_inserted,
  input  logic              ticket_ok,
  input  logic [DWIDTH-1:0] parking_time_min,
  input  logic              bill_2,
  input  logic              bill_4,
  input  logic              attendant_clear,
  output logic [7:0]        fee_display,
  output logic              exit_gate,
  output logic              thank_you_lamp,
  output logic              see_attendant_lamp,
  output logic              ticket_eject
);

  // ---------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------
  localparam logic [2:0] IDLE_X      = 3'd0;
  localparam logic [2:0] CALC_FEE    = 3'd1;
  localparam logic [2:0] WAIT_PAY    = 3'd2;
  localparam logic [2:0] X_GATE_OPEN = 3'd3;
  localparam logic [2:0] ERROR       = 3'd4;

  // ---------------------------------------------------------------------
  // Timing constants
  // ---------------------------------------------------------------------
  // The payment timeout at default settings is 6e9 cycles. That does not
  // fit in 32 bits, so all cycle counts are calculated in 64 bits.
  localparam longint unsigned PAY_CYCLES   = 64'(PAY_TIMEOUT_SEC) * 64'(TICKS_PER_SEC);
  localparam longint unsigned GATE_CYCLES  = 64'(GATE_TIMEOUT_SEC) * 64'(TICKS_PER_SEC);
  localparam longint unsigned HALF_CYCLES  = 64'(TICKS_PER_SEC / 2);
  localparam longint unsigned BLINK_CYCLES = 3 * HALF_CYCLES;
  localparam longint unsigned TICK_MAX     = (PAY_CYCLES > GATE_CYCLES) ? PAY_CYCLES
                                                                         : GATE_CYCLES;

  localparam int TW = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int BW = (BLINK_CYCLES > 0) ? $clog2(BLINK_CYCLES + 1) : 1;

  // The tick counter starts at 0 when a state is entered. When it reaches
  // *_LAST, that many cycles have been spent in the state.
  localparam logic [TW-1:0] PAY_LAST    = TW'(PAY_CYCLES - 1);
  localparam logic [TW-1:0] GATE_LAST   = TW'(GATE_CYCLES - 1);

  // The blink counter counts down from BLINK_START to 0. The lamp is lit
  // during the top third and the bottom third of that range.
  localparam logic [BW-1:0] BLINK_START = BW'(BLINK_CYCLES);
  localparam logic [BW-1:0] BLINK_HALF  = BW'(HALF_CYCLES);
  localparam logic [BW-1:0] BLINK_TWO_H = BW'(2 * HALF_CYCLES);

  localparam logic [6:0]        MAX_BAL = 7'(MAX_FEE);
  localparam logic [DWIDTH-1:0] HOUR    = DWIDTH'(60);

  // ---------------------------------------------------------------------
  // Registers and their next-state values
  // ---------------------------------------------------------------------
  logic [2:0]        state_q,   state_d;
  logic [6:0]        balance_q, balance_d;
  logic [DWIDTH-1:0] r_q,       r_d;
  logic [TW-1:0]     tick_q,    tick_d;
  logic [BW-1:0]     blink_q,   blink_d;
  logic              sens_q;

  logic [7:0]        fee_q,     fee_d;
  logic              gate_q,    gate_d;
  logic              lamp_q,    lamp_d;
  logic              attend_q,  attend_d;
  logic              eject_q,   eject_d;

  logic              restart_tick;
  logic              sensor_fell;
  logic              bill_any;
  logic [6:0]        bill_amt;

  // A falling edge is detected against last cycle's sensor value.
  assign sensor_fell = sens_q & ~exit_sensor;
  assign bill_any    = bill_2 | bill_4;
  // bill_2 has weight 2 and bill_4 has weight 4. Both together give 6.
  assign bill_amt    = {4'd0, bill_4, bill_2, 1'b0};

  // Converts a balance (0..98) into two BCD digits, with the tens in [7:4].
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 7'd10);
    ones = 4'(v % 7'd10);
    return {tens, ones};
  endfunction

  // ---------------------------------------------------------------------
  // Next-state logic for the FSM, the fee remainder and the balance
  // ---------------------------------------------------------------------
  // Computes the next state, the fee iteration, bill handling and the
  // eject pulse.
  always_comb begin
    // NOTE: every variable written in this block gets a default value first.
    // If a path through the case statement skipped an assignment, synthesis
    // would infer a latch to hold the old value.
    state_d      = state_q;
    balance_d    = balance_q;
    r_d          = r_q;
    eject_d      = 1'b0;
    restart_tick = 1'b0;

    case (state_q)
      IDLE_X: begin
        // A ticket with no car in the lane is ignored.
        if (ticket_inserted && exit_sensor) begin
          if (ticket_ok) begin
            r_d       = parking_time_min;
            balance_d = '0;
            state_d   = CALC_FEE;
          end else begin
            state_d   = ERROR;
          end
        end
      end

      CALC_FEE: begin
        // Each cycle charges one started hour, until the time is used up or
        // the cap is reached. MAX_FEE is even, so the balance reaches the
        // cap exactly.
        if ((r_q != '0) && (balance_q < MAX_BAL)) begin
          r_d       = (r_q > HOUR) ? (r_q - HOUR) : '0;
          balance_d = balance_q + 7'd2;
        end else if (balance_q == '0) begin
          state_d   = X_GATE_OPEN;
        end else begin
          state_d   = WAIT_PAY;
        end
      end

      WAIT_PAY: begin
        if (balance_q == '0) begin
          // The balance reached zero last cycle, so the gate opens now.
          state_d = X_GATE_OPEN;
        end else if (sensor_fell || ((tick_q == PAY_LAST) && !bill_any)) begin
          // The car left or the customer stopped paying: give the ticket back.
          eject_d   = 1'b1;
          balance_d = '0;
          state_d   = IDLE_X;
        end else if (bill_any) begin
          // Overpayment is kept; the balance saturates at zero.
          balance_d    = (balance_q > bill_amt) ? (balance_q - bill_amt) : '0;
          restart_tick = 1'b1;
        end
      end

      X_GATE_OPEN: begin
        // The gate closes when the car passes or when the timeout expires,
        // whichever happens first.
        if (sensor_fell || (tick_q == GATE_LAST)) begin
          state_d = IDLE_X;
        end
      end

      ERROR: begin
        if (attendant_clear) begin
          state_d = IDLE_X;
        end
      end

      default: begin
        state_d = IDLE_X;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Shared tick counter and the independent blink counter
  // ---------------------------------------------------------------------
  // The tick counter restarts on every state change and on each accepted
  // bill. The blink counter is reloaded when X_GATE_OPEN is entered and then
  // counts down to zero, even after the state has moved on.
  always_comb begin
    if ((state_d != state_q) || restart_tick) begin
      tick_d = '0;
    end else begin
      tick_d = tick_q + TW'(1);
    end

    if ((state_d == X_GATE_OPEN) && (state_q != X_GATE_OPEN)) begin
      blink_d = BLINK_START;
    end else if (blink_q != '0) begin
      blink_d = blink_q - BW'(1);
    end else begin
      blink_d = '0;
    end
  end

  // ---------------------------------------------------------------------
  // Output decode from the next-state values
  // ---------------------------------------------------------------------
  // Computes the output values that the output flops will load, so each
  // output changes on the same edge as the state it reflects.
  always_comb begin
    fee_d    = ((state_d == CALC_FEE) || (state_d == WAIT_PAY)) ? to_bcd(balance_d)
                                                                : 8'h00;
    gate_d   = (state_d == X_GATE_OPEN);
    attend_d = (state_d == ERROR);
    // Lit for the first half second, dark for the second, lit for the third.
    lamp_d   = (blink_d > BLINK_TWO_H) || ((blink_d != '0) && (blink_d <= BLINK_HALF));
  end

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  // Holds the FSM state, the balance, the fee remainder, both timers and the
  // delayed sensor sample.
  always_ff @(posedge clk) begin
    // NOTE: this design has no memory arrays. Every flop is a control or
    // datapath register, so every flop is cleared by reset. Reset is checked
    // before any other input, so it takes priority over all of them.
    if (reset) begin
      state_q   <= IDLE_X;
      balance_q <= '0;
      r_q       <= '0;
      tick_q    <= '0;
      blink_q   <= '0;
      sens_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. All flops
      // sample their _d values from before the edge, so the order of these
      // statements does not matter.
      state_q   <= state_d;
      balance_q <= balance_d;
      r_q       <= r_d;
      tick_q    <= tick_d;
      blink_q   <= blink_d;
      sens_q    <= exit_sensor;
    end
  end

  // ---------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------
  // Output flops. Reset drives every output to 0 on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      fee_q    <= 8'h00;
      gate_q   <= 1'b0;
      lamp_q   <= 1'b0;
      attend_q <= 1'b0;
      eject_q  <= 1'b0;
    end else begin
      fee_q    <= fee_d;
      gate_q   <= gate_d;
      lamp_q   <= lamp_d;
      attend_q <= attend_d;
      eject_q  <= eject_d;
    end
  end

  assign fee_display        = fee_q;
  assign exit_gate          = gate_q;
  assign thank_you_lamp     = lamp_q;
  assign see_attendant_lamp = attend_q;
  assign ticket_eject       = eject_q;

endmodule
